// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver: state encoding,
// config field positions, word-size limits and small bit helpers.
package uart_rx_os_pkg;

  localparam int unsigned DATA_W       = 9;
  localparam int unsigned CFG_W        = 7;
  localparam int unsigned CFG_STORE    = 0;
  localparam int unsigned CFG_WS_LSB   = 1;
  localparam int unsigned CFG_WS_MSB   = 4;
  localparam int unsigned CFG_PAR_EN   = 5;
  localparam int unsigned CFG_TWO_STOP = 6;

  localparam logic [3:0] WS_MIN   = 4'd5;
  localparam logic [3:0] WS_MAX   = 4'd9;
  localparam logic [3:0] WS_RESET = 4'd8;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_BREAK  = 6'b100000
  } state_t;

  typedef struct packed {
    logic       two_stop;
    logic       par_en;
    logic [3:0] word_size;
  } rx_cfg_t;

  function automatic logic [3:0] clamp_ws(input logic [3:0] ws);
    if (ws < WS_MIN) return WS_MIN;
    if (ws > WS_MAX) return WS_MAX;
    return ws;
  endfunction

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic parity9(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_fifo.sv
// First-word-fall-through receive FIFO with occupancy count and a drop strobe
// for pushes refused while full.
module uart_rx_os_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CW-1:0]    count_next_c;

  // A pop frees the slot the same cycle, so push is legal when full if popping.
  always_comb begin
    pop_ok_c     = pop & valid;
    push_ok_c    = push & ((count != CW'(DEPTH)) | pop_ok_c);
    drop_c       = push & ~push_ok_c;
    count_next_c = count;
    if (push_ok_c && !pop_ok_c)      count_next_c = count + CW'(1);
    else if (!push_ok_c && pop_ok_c) count_next_c = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next_c;
      valid <= (count_next_c != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= wdata;
  end

  assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised line, 3-sample majority per bit,
// parity/frame/overrun/break detection and a FWFT receive FIFO.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [6:0]                        i_config,
  input  logic                              i_sample_tick,
  input  logic                              i_rx,
  output logic [8:0]                        o_rx_parallel,
  output logic                              o_rx_valid,
  input  logic                              i_rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count,
  output logic                              o_ready,
  output logic                              o_parity_error,
  output logic                              o_frame_error,
  output logic                              o_overrun,
  output logic                              o_break,
  input  logic                              i_err_clear
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = OVERSAMPLE / 2;

  state_t              state, state_next;
  rx_cfg_t             cfg;
  logic                rx_meta, rx_sync;
  logic [1:0]          hist;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          bit_idx;
  logic [DATA_W-1:0]   data;
  logic                par_bad, stop_idx, stop_bad, stop_zero;
  logic                vote_c, mid_c, end_c, last_bit_c, last_stop_c;
  logic                push_c, set_par_c, set_frame_c, set_break_c, drop_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // Vote uses the two previous tick samples plus the current one.
  assign vote_c      = maj3(hist[1], hist[0], rx_sync);
  assign mid_c       = i_sample_tick && (cnt == CNT_W'(MID));
  assign end_c       = i_sample_tick && (cnt == CNT_W'(OVERSAMPLE - 1));
  assign last_bit_c  = (bit_idx == cfg.word_size - 4'd1);
  assign last_stop_c = (stop_idx == cfg.two_stop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    push_c      = 1'b0;
    set_par_c   = 1'b0;
    set_frame_c = 1'b0;
    set_break_c = 1'b0;
    case (state)
      ST_IDLE:   if (i_sample_tick && !rx_sync) state_next = ST_START;
      ST_START:  if (mid_c) state_next = vote_c ? ST_IDLE : ST_DATA;
      ST_DATA:   if (end_c && last_bit_c) state_next = cfg.par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (end_c) state_next = ST_STOP;
      ST_STOP: begin
        if (end_c && last_stop_c) begin
          state_next = ST_IDLE;
          if (stop_bad || !vote_c) begin
            set_frame_c = 1'b1;
            if ((data == '0) && stop_zero && !vote_c) begin
              set_break_c = 1'b1;
              state_next  = ST_BREAK;
            end
          end else if (par_bad) begin
            set_par_c = 1'b1;
          end else begin
            push_c = 1'b1;
          end
        end
      end
      ST_BREAK:  if (end_c && rx_sync) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Per-frame datapath; everything is re-armed while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist      <= 2'b11;
      cnt       <= '0;
      bit_idx   <= '0;
      data      <= '0;
      par_bad   <= 1'b0;
      stop_idx  <= 1'b0;
      stop_bad  <= 1'b0;
      stop_zero <= 1'b1;
      cfg       <= '{two_stop: 1'b0, par_en: 1'b0, word_size: WS_RESET};
    end else begin
      if (i_sample_tick) hist <= {hist[0], rx_sync};
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          data      <= '0;
          par_bad   <= 1'b0;
          stop_idx  <= 1'b0;
          stop_bad  <= 1'b0;
          stop_zero <= 1'b1;
          if (i_config[CFG_STORE]) begin
            cfg <= '{two_stop:  i_config[CFG_TWO_STOP],
                     par_en:    i_config[CFG_PAR_EN],
                     word_size: clamp_ws(i_config[CFG_WS_MSB:CFG_WS_LSB])};
          end
        end
        ST_START: if (i_sample_tick) cnt <= mid_c ? '0 : cnt + CNT_W'(1);
        ST_DATA: begin
          if (i_sample_tick) cnt <= end_c ? '0 : cnt + CNT_W'(1);
          if (end_c) begin
            data[bit_idx] <= vote_c;
            bit_idx       <= bit_idx + 4'd1;
          end
        end
        ST_PARITY: begin
          if (i_sample_tick) cnt <= end_c ? '0 : cnt + CNT_W'(1);
          if (end_c) par_bad <= (vote_c != parity9(data));
        end
        ST_STOP: begin
          if (i_sample_tick) cnt <= end_c ? '0 : cnt + CNT_W'(1);
          if (end_c) begin
            stop_idx  <= 1'b1;
            stop_bad  <= stop_bad | ~vote_c;
            stop_zero <= stop_zero & ~vote_c;
          end
        end
        ST_BREAK: if (i_sample_tick) cnt <= rx_sync ? cnt + CNT_W'(1) : '0;
        default: ;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear keeps the flag high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_overrun      <= 1'b0;
      o_break        <= 1'b0;
    end else begin
      o_ready        <= (state_next == ST_IDLE);
      o_parity_error <= set_par_c   | (o_parity_error & ~i_err_clear);
      o_frame_error  <= set_frame_c | (o_frame_error  & ~i_err_clear);
      o_overrun      <= drop_c      | (o_overrun      & ~i_err_clear);
      o_break        <= set_break_c | (o_break        & ~i_err_clear);
    end
  end

  uart_rx_os_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .push   (push_c),
    .wdata  (data),
    .pop    (i_rx_ready),
    .rdata  (o_rx_parallel),
    .valid  (o_rx_valid),
    .count  (o_fifo_count),
    .drop_c (drop_c)
  );

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: serial frames driven tick by tick, outcomes predicted
// by a frame-level model (expected word queue plus sticky flag copies).
module tb_uart_rx_os;

  localparam int unsigned OS         = 16;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned IDLE_TICKS = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cfg_in = '0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       err_clear = 1'b0;
  logic [8:0] rx_par;
  logic       rx_valid;
  logic [3:0] fifo_count;
  logic       rdy, perr, ferr, ovr, brk;

  int vectors = 0;
  int errors  = 0;
  int div     = 0;

  logic [8:0] exp_q[$];
  bit m_par, m_frame, m_over, m_break;
  int cur_ws  = 8;
  bit cur_pen = 1'b0;
  bit cur_two = 1'b0;

  uart_rx_os #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_config       (cfg_in),
    .i_sample_tick  (tick),
    .i_rx           (rx),
    .o_rx_parallel  (rx_par),
    .o_rx_valid     (rx_valid),
    .i_rx_ready     (ready),
    .o_fifo_count   (fifo_count),
    .o_ready        (rdy),
    .o_parity_error (perr),
    .o_frame_error  (ferr),
    .o_overrun      (ovr),
    .o_break        (brk),
    .i_err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div  = (div + 1) % TICK_DIV;
    tick = (div == 0);
  end

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk iff tick);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    wait_ticks(n);
  endtask

  task automatic set_cfg(input int ws_raw, input bit pen, input bit two);
    cfg_in = {two, pen, 4'(ws_raw), 1'b1};
    @(posedge clk); #1;
    cfg_in[0] = 1'b0;
    cur_ws  = (ws_raw < 5) ? 5 : ((ws_raw > 9) ? 9 : ws_raw);
    cur_pen = pen;
    cur_two = two;
  endtask

  task automatic send_frame(input logic [8:0] d, input bit bad_par, input bit stop_v);
    logic p;
    p = 1'b0;
    drive(1'b0, OS);
    for (int i = 0; i < cur_ws; i++) begin
      drive(d[i], OS);
      p ^= d[i];
    end
    if (cur_pen) drive(p ^ bad_par, OS);
    drive(stop_v, OS);
    if (cur_two) drive(stop_v, OS);
    drive(1'b1, IDLE_TICKS);
  endtask

  // Frame-level expectation: stop error wins, then parity, then FIFO capacity.
  function automatic void model_frame(input logic [8:0] d, input bit bad_par, input bit stop_v);
    logic [8:0] word;
    word = d & 9'((1 << cur_ws) - 1);
    if (!stop_v) begin
      m_frame = 1'b1;
      if (word == 9'd0) m_break = 1'b1;
    end else if (cur_pen && bad_par) begin
      m_par = 1'b1;
    end else if (exp_q.size() == DEPTH) begin
      m_over = 1'b1;
    end else begin
      exp_q.push_back(word);
    end
  endfunction

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    {m_par, m_frame, m_over, m_break} = '0;
  endtask

  task automatic pop_one(output logic [8:0] w);
    w = rx_par;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({rx_par, rx_valid, fifo_count, rdy, perr, ferr, ovr, brk} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got par=%h v=%b cnt=%0d rdy=%b flags=%b%b%b%b exp all 0",
               rx_par, rx_valid, fifo_count, rdy, perr, ferr, ovr, brk);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy); end
  endtask

  task automatic test_basic();
    logic [8:0] w;
    send_frame(9'h0A5, 1'b0, 1'b1);
    model_frame(9'h0A5, 1'b0, 1'b1);
    vectors++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rx_valid); end
    vectors++;
    if (rx_par !== 9'h0A5) begin errors++; $display("FAIL basic_data got %h exp 0a5", rx_par); end
    vectors++;
    if (fifo_count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", fifo_count); end
    pop_one(w);
    void'(exp_q.pop_front());
    vectors++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b exp 0", rx_valid); end
  endtask

  task automatic test_glitch();
    drive(1'b0, 4);
    drive(1'b1, 40);
    vectors++;
    if ({fifo_count, perr, ferr, ovr, brk} !== '0) begin
      errors++;
      $display("FAIL glitch_quiet got cnt=%0d flags=%b%b%b%b exp 0", fifo_count, perr, ferr, ovr, brk);
    end
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL glitch_ready got %b exp 1", rdy); end
  endtask

  task automatic test_parity();
    logic [8:0] w;
    set_cfg(7, 1'b1, 1'b0);
    send_frame(9'h041, 1'b1, 1'b1);
    model_frame(9'h041, 1'b1, 1'b1);
    vectors++;
    if (perr !== m_par) begin errors++; $display("FAIL parity_flag got %b exp %b", perr, m_par); end
    vectors++;
    if (fifo_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL parity_count got %0d exp %0d", fifo_count, exp_q.size());
    end
    pulse_clear();
    vectors++;
    if (perr !== 1'b0) begin errors++; $display("FAIL parity_clear got %b exp 0", perr); end
    send_frame(9'h041, 1'b0, 1'b1);
    model_frame(9'h041, 1'b0, 1'b1);
    vectors++;
    if (rx_par !== exp_q[0]) begin errors++; $display("FAIL parity_good_data got %h exp %h", rx_par, exp_q[0]); end
    pop_one(w);
    void'(exp_q.pop_front());
  endtask

  task automatic test_overrun();
    logic [8:0] w;
    logic [8:0] e;
    set_cfg(8, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      send_frame(9'(i), 1'b0, 1'b1);
      model_frame(9'(i), 1'b0, 1'b1);
    end
    vectors++;
    if (fifo_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL overrun_count got %0d exp %0d", fifo_count, exp_q.size());
    end
    vectors++;
    if (ovr !== m_over) begin errors++; $display("FAIL overrun_flag got %b exp %b", ovr, m_over); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(w);
      vectors++;
      if (w !== e) begin errors++; $display("FAIL overrun_pop got %h exp %h", w, e); end
    end
    vectors++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_drained got %b exp 0", rx_valid); end
    pulse_clear();
  endtask

  task automatic test_break();
    logic [8:0] w;
    drive(1'b0, 20 * OS);
    drive(1'b1, IDLE_TICKS);
    m_frame = 1'b1;
    m_break = 1'b1;
    vectors++;
    if ({ferr, brk} !== {m_frame, m_break}) begin
      errors++; $display("FAIL break_flags got fe=%b brk=%b exp 1 1", ferr, brk);
    end
    vectors++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL break_count got %0d exp 0", fifo_count); end
    pulse_clear();
    send_frame(9'h03C, 1'b0, 1'b1);
    model_frame(9'h03C, 1'b0, 1'b1);
    vectors++;
    if (rx_par !== exp_q[0] || fifo_count !== 4'd1) begin
      errors++; $display("FAIL break_recover got %h cnt=%0d exp %h cnt=1", rx_par, fifo_count, exp_q[0]);
    end
    pop_one(w);
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    set_cfg(8, 1'b0, 1'b1);
    send_frame(9'h012, 1'b0, 1'b1);
    drive(1'b0, OS);
    drive(1'b1, 2 * OS + OS / 2);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rx_par, rx_valid, fifo_count, rdy, perr, ferr, ovr, brk} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got par=%h v=%b cnt=%0d rdy=%b exp all 0",
               rx_par, rx_valid, fifo_count, rdy);
    end
    exp_q.delete();
    {m_par, m_frame, m_over, m_break} = '0;
    cur_ws = 8; cur_pen = 1'b0; cur_two = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    set_cfg(8, 1'b0, 1'b1);
    fork
      send_frame(9'h0FF, 1'b0, 1'b1);
      begin
        wait_ticks(3 * OS);
        cfg_in = {1'b0, 1'b0, 4'd5, 1'b1};
        @(posedge clk); #1;
        cfg_in[0] = 1'b0;
      end
    join
    model_frame(9'h0FF, 1'b0, 1'b1);
    vectors++;
    if (rx_par !== exp_q[0] || fifo_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL reset_mid_frame got %h cnt=%0d exp %h cnt=%0d",
                         rx_par, fifo_count, exp_q[0], exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [8:0] d, w, e;
    bit bad_par, stop_v;
    int npop;
    for (int n = 0; n < 16; n++) begin
      set_cfg(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      d = 9'($urandom);
      if ($urandom_range(0, 7) == 0) d = '0;
      bad_par = cur_pen && ($urandom_range(0, 4) == 0);
      stop_v  = ($urandom_range(0, 6) != 0);
      send_frame(d, bad_par, stop_v);
      model_frame(d, bad_par, stop_v);
      vectors++;
      if (fifo_count !== 4'(exp_q.size()) || rx_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_count n=%0d got %0d/%b exp %0d", n, fifo_count, rx_valid, exp_q.size());
      end
      vectors++;
      if ({perr, ferr, ovr, brk} !== {m_par, m_frame, m_over, m_break}) begin
        errors++; $display("FAIL rand_flags n=%0d got %b%b%b%b exp %b%b%b%b", n,
                           perr, ferr, ovr, brk, m_par, m_frame, m_over, m_break);
      end
      npop = int'($urandom_range(0, 2));
      for (int k = 0; k < npop && exp_q.size() > 0; k++) begin
        e = exp_q.pop_front();
        pop_one(w);
        vectors++;
        if (w !== e) begin errors++; $display("FAIL rand_pop n=%0d got %h exp %h", n, w, e); end
      end
      pulse_clear();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_one(w);
      vectors++;
      if (w !== e) begin errors++; $display("FAIL rand_drain got %h exp %h", w, e); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired after %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_overrun();
    test_break();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
